// File: rtl/id_hazard_scoreboard.sv
// Decode-stage issue control: per-register pending-write counters stall RAW/WAW hazards.
// Latency: 1 cycle from ID acceptance to ex_valid_o, through a registered valid/ready stage.
// Backpressure: id_ready_o drops on hazard, flush, or a full EX register that execute is not taking.
module id_hazard_scoreboard #(
    parameter int CNT_W = 2,
    parameter int NREGS = 32
) (
    input  logic        clk,
    input  logic        rstn_i,
    input  logic        flush_i,
    input  logic        id_valid_i,
    output logic        id_ready_o,
    input  logic [4:0]  rs1_i,
    input  logic        rs1_used_i,
    input  logic [4:0]  rs2_i,
    input  logic        rs2_used_i,
    input  logic [4:0]  rd_i,
    input  logic        rd_wr_i,
    input  logic [31:0] imm_i,
    output logic        ex_valid_o,
    input  logic        ex_ready_i,
    output logic [4:0]  ex_rs1_o,
    output logic [4:0]  ex_rs2_o,
    output logic [4:0]  ex_rd_o,
    output logic        ex_rd_wr_o,
    output logic [31:0] ex_imm_o,
    input  logic        wb_valid_i,
    input  logic [4:0]  wb_rd_i,
    output logic        busy_o,
    output logic        err_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_wr;
        logic [31:0] imm;
    } ex_dat_t;

    logic [CNT_W-1:0] cnt_q [NREGS];
    logic [CNT_W-1:0] cnt_d [NREGS];
    ex_dat_t          ex_dat_q, ex_dat_d;
    logic             ex_vld_q, ex_vld_d;
    logic             err_q, err_d;

    logic [CNT_W-1:0] cnt_rs1, cnt_rs2, cnt_rd, cnt_wb;
    logic             raw_hzd, waw_hzd, hazard;
    logic             issue, wb_act, wb_orphan;
    logic [NREGS-1:0] inc_vec, dec_vec;
    logic             busy;

    assign cnt_rs1 = cnt_q[rs1_i];
    assign cnt_rs2 = cnt_q[rs2_i];
    assign cnt_rd  = cnt_q[rd_i];
    assign cnt_wb  = cnt_q[wb_rd_i];

    // Hazards look only at registered counts; a same-cycle writeback does not unblock.
    assign raw_hzd = (rs1_used_i && (rs1_i != 5'd0) && (cnt_rs1 != '0))
                   || (rs2_used_i && (rs2_i != 5'd0) && (cnt_rs2 != '0));
    assign waw_hzd = rd_wr_i && (rd_i != 5'd0) && (cnt_rd == CNT_MAX);
    assign hazard  = raw_hzd || waw_hzd;

    assign id_ready_o = !flush_i && !hazard && (!ex_vld_q || ex_ready_i);
    assign issue      = id_valid_i && id_ready_o;
    assign wb_act     = wb_valid_i && !flush_i && (wb_rd_i != 5'd0);

    // A writeback with nothing pending is only legal if an issue to that register lands this cycle.
    assign wb_orphan = wb_act && (cnt_wb == '0)
                     && !(issue && rd_wr_i && (rd_i == wb_rd_i));

    assign inc_vec = (issue && rd_wr_i) ? ((NREGS'(1) << rd_i) & ~NREGS'(1)) : '0;
    assign dec_vec = wb_act ? ((NREGS'(1) << wb_rd_i) & ~NREGS'(1)) : '0;

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (flush_i) begin
                cnt_d[r] = '0;
            end else if (inc_vec[r] && !dec_vec[r]) begin
                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (dec_vec[r] && !inc_vec[r] && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
        end
        cnt_d[0] = '0;
    end

    always_comb begin
        ex_vld_d = ex_vld_q;
        ex_dat_d = ex_dat_q;
        if (flush_i) begin
            ex_vld_d = 1'b0;
        end else if (issue) begin
            ex_vld_d       = 1'b1;
            ex_dat_d.rs1   = rs1_i;
            ex_dat_d.rs2   = rs2_i;
            ex_dat_d.rd    = rd_i;
            ex_dat_d.rd_wr = rd_wr_i;
            ex_dat_d.imm   = imm_i;
        end else if (ex_ready_i) begin
            ex_vld_d = 1'b0;
        end
    end

    assign err_d = err_q || wb_orphan;

    always_comb begin
        busy = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            busy = busy || (cnt_q[r] != '0);
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= '0;
            end
            ex_vld_q <= 1'b0;
            ex_dat_q <= '0;
            err_q    <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            ex_vld_q <= ex_vld_d;
            ex_dat_q <= ex_dat_d;
            err_q    <= err_d;
        end
    end

    assign ex_valid_o = ex_vld_q;
    assign ex_rs1_o   = ex_dat_q.rs1;
    assign ex_rs2_o   = ex_dat_q.rs2;
    assign ex_rd_o    = ex_dat_q.rd;
    assign ex_rd_wr_o = ex_dat_q.rd_wr;
    assign ex_imm_o   = ex_dat_q.imm;
    assign busy_o     = busy;
    assign err_o      = err_q;

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Bench for id_hazard_scoreboard: pending-write counts kept as plain integers per register,
// checked every cycle, plus directed scenarios with literal expectations.
module tb_id_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rstn_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        id_valid_i = 1'b0;
    logic        id_ready_o;
    logic [4:0]  rs1_i = '0;
    logic        rs1_used_i = 1'b0;
    logic [4:0]  rs2_i = '0;
    logic        rs2_used_i = 1'b0;
    logic [4:0]  rd_i = '0;
    logic        rd_wr_i = 1'b0;
    logic [31:0] imm_i = '0;
    logic        ex_valid_o;
    logic        ex_ready_i = 1'b1;
    logic [4:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;
    logic        ex_rd_wr_o;
    logic [31:0] ex_imm_o;
    logic        wb_valid_i = 1'b0;
    logic [4:0]  wb_rd_i = '0;
    logic        busy_o;
    logic        err_o;

    int n_checks = 0;
    int n_errors = 0;

    id_hazard_scoreboard #(.CNT_W(2), .NREGS(32)) dut (
        .clk(clk), .rstn_i(rstn_i), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
        .rs1_i(rs1_i), .rs1_used_i(rs1_used_i), .rs2_i(rs2_i), .rs2_used_i(rs2_used_i),
        .rd_i(rd_i), .rd_wr_i(rd_wr_i), .imm_i(imm_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o),
        .ex_rd_wr_o(ex_rd_wr_o), .ex_imm_o(ex_imm_o),
        .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Reference state: number of outstanding writes per register, and the EX slot contents.
    int          m_cnt [32];
    bit          m_vld;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic        m_rd_wr;
    logic [31:0] m_imm;
    bit          m_err;

    localparam int MAXC = 3;

    function automatic bit m_ready();
        bit blocked;
        blocked = 1'b0;
        if (rs1_used_i && rs1_i != 0 && m_cnt[rs1_i] > 0) blocked = 1'b1;
        if (rs2_used_i && rs2_i != 0 && m_cnt[rs2_i] > 0) blocked = 1'b1;
        if (rd_wr_i && rd_i != 0 && m_cnt[rd_i] >= MAXC) blocked = 1'b1;
        return !flush_i && !blocked && (!m_vld || ex_ready_i);
    endfunction

    function automatic bit m_busy();
        for (int r = 0; r < 32; r++) if (m_cnt[r] != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rstn_i) begin
            for (int r = 0; r < 32; r++) m_cnt[r] = 0;
            m_vld = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_rd_wr = 0; m_imm = 0; m_err = 0;
        end else if (flush_i) begin
            for (int r = 0; r < 32; r++) m_cnt[r] = 0;
            m_vld = 0;
        end else begin
            bit iss;
            bit same;
            iss = id_valid_i && m_ready();
            same = iss && rd_wr_i && rd_i == wb_rd_i;
            if (wb_valid_i && wb_rd_i != 0) begin
                if (m_cnt[wb_rd_i] == 0 && !same) m_err = 1;
                else if (m_cnt[wb_rd_i] > 0) m_cnt[wb_rd_i] = m_cnt[wb_rd_i] - 1;
                else m_cnt[wb_rd_i] = m_cnt[wb_rd_i] - 1;
            end
            if (iss) begin
                if (rd_wr_i && rd_i != 0) m_cnt[rd_i] = m_cnt[rd_i] + 1;
                m_vld = 1; m_rs1 = rs1_i; m_rs2 = rs2_i; m_rd = rd_i;
                m_rd_wr = rd_wr_i; m_imm = imm_i;
            end else if (ex_ready_i) begin
                m_vld = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rstn_i) begin
            chk("id_ready", 32'(id_ready_o), 32'(m_ready()));
            chk("ex_valid", 32'(ex_valid_o), 32'(m_vld));
            chk("ex_rs1", 32'(ex_rs1_o), 32'(m_rs1));
            chk("ex_rs2", 32'(ex_rs2_o), 32'(m_rs2));
            chk("ex_rd", 32'(ex_rd_o), 32'(m_rd));
            chk("ex_rd_wr", 32'(ex_rd_wr_o), 32'(m_rd_wr));
            chk("ex_imm", ex_imm_o, m_imm);
            chk("busy", 32'(busy_o), 32'(m_busy()));
            chk("err", 32'(err_o), 32'(m_err));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        id_valid_i = 0; rs1_used_i = 0; rs2_used_i = 0; rd_wr_i = 0;
        rs1_i = 0; rs2_i = 0; rd_i = 0; wb_valid_i = 0; wb_rd_i = 0; flush_i = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rstn_i = 1;
        #1;
        chk("rst_ex_valid", 32'(ex_valid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_ex_imm", ex_imm_o, 32'd0);
        chk("rst_ready", 32'(id_ready_o), 32'd1);

        // RAW: writer of x5, then reader of x5 stalls until writeback retires it
        id_valid_i = 1; rd_i = 5; rd_wr_i = 1;
        step();
        rd_i = 0; rd_wr_i = 0; rs1_i = 5; rs1_used_i = 1;
        #1 chk("raw_stall", 32'(id_ready_o), 32'd0);
        repeat (3) step();
        chk("raw_still_stall", 32'(id_ready_o), 32'd0);
        wb_valid_i = 1; wb_rd_i = 5;
        #1 chk("raw_no_bypass", 32'(id_ready_o), 32'd0);
        step();
        wb_valid_i = 0;
        #1 chk("raw_release", 32'(id_ready_o), 32'd1);
        step();
        idle_in();

        // x0 is never tracked
        id_valid_i = 1; rd_i = 0; rd_wr_i = 1;
        step();
        rd_wr_i = 0; rs1_i = 0; rs1_used_i = 1;
        #1 chk("x0_no_stall", 32'(id_ready_o), 32'd1);
        step();
        chk("x0_busy", 32'(busy_o), 32'd0);
        idle_in();

        // WAW saturation on x7
        id_valid_i = 1; rd_i = 7; rd_wr_i = 1;
        repeat (3) step();
        chk("model_cnt7_3", 32'(m_cnt[7]), 32'd3);
        chk("waw_stall", 32'(id_ready_o), 32'd0);
        wb_valid_i = 1; wb_rd_i = 7;
        #1 chk("waw_no_bypass", 32'(id_ready_o), 32'd0);
        step();
        chk("model_cnt7_2", 32'(m_cnt[7]), 32'd2);
        chk("waw_ready_again", 32'(id_ready_o), 32'd1);
        step();
        chk("model_cnt7_same", 32'(m_cnt[7]), 32'd2);
        wb_valid_i = 0;
        step();
        chk("waw_stall_again", 32'(id_ready_o), 32'd0);
        id_valid_i = 0; wb_valid_i = 1; wb_rd_i = 7;
        repeat (3) step();
        idle_in();
        #1 chk("waw_drained", 32'(busy_o), 32'd0);

        // EX backpressure
        step();
        ex_ready_i = 0; id_valid_i = 1; rs1_i = 3; rs1_used_i = 1; imm_i = 32'hDEADBEEF;
        #1 chk("bp_first_ready", 32'(id_ready_o), 32'd1);
        step();
        imm_i = 32'h12345678; rs1_i = 4;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_ready_low", 32'(id_ready_o), 32'd0);
            chk("bp_imm_hold", ex_imm_o, 32'hDEADBEEF);
            chk("bp_rs1_hold", 32'(ex_rs1_o), 32'd3);
            step();
        end
        ex_ready_i = 1;
        #1 chk("bp_release_ready", 32'(id_ready_o), 32'd1);
        step();
        chk("bp_new_imm", ex_imm_o, 32'h12345678);
        idle_in();

        // Orphan writeback sets the sticky error
        wb_valid_i = 1; wb_rd_i = 9;
        step();
        wb_valid_i = 0;
        #1 chk("err_set", 32'(err_o), 32'd1);

        // Flush clears counters and EX slot but keeps err_o
        id_valid_i = 1; rd_i = 3; rd_wr_i = 1;
        step();
        chk("pre_flush_busy", 32'(busy_o), 32'd1);
        rd_i = 4; flush_i = 1; wb_valid_i = 1; wb_rd_i = 3;
        #1 chk("flush_blocks", 32'(id_ready_o), 32'd0);
        step();
        idle_in();
        #1;
        chk("flush_busy", 32'(busy_o), 32'd0);
        chk("flush_ex_valid", 32'(ex_valid_o), 32'd0);
        chk("flush_err_kept", 32'(err_o), 32'd1);

        // Asynchronous reset mid-stream
        id_valid_i = 1; rd_i = 5; rd_wr_i = 1;
        repeat (2) step();
        chk("model_cnt5_2", 32'(m_cnt[5]), 32'd2);
        idle_in();
        #1 rstn_i = 0;
        #1;
        chk("arst_ex_valid", 32'(ex_valid_o), 32'd0);
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_err", 32'(err_o), 32'd0);
        step();
        rstn_i = 1;
        step();

        // Mixed traffic on a few registers to stress the counters
        for (int i = 0; i < 400; i++) begin
            id_valid_i = ($urandom_range(0, 3) != 0);
            rs1_i = 5'($urandom_range(0, 3)); rs1_used_i = 1'($urandom_range(0, 1));
            rs2_i = 5'($urandom_range(0, 3)); rs2_used_i = 1'($urandom_range(0, 1));
            rd_i = 5'($urandom_range(0, 3)); rd_wr_i = ($urandom_range(0, 3) != 0);
            imm_i = $urandom;
            ex_ready_i = ($urandom_range(0, 3) != 0);
            wb_valid_i = ($urandom_range(0, 2) == 0);
            wb_rd_i = 5'($urandom_range(0, 3));
            flush_i = ($urandom_range(0, 29) == 0);
            step();
        end
        idle_in();
        ex_ready_i = 1;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
